// File: rtl/down_counter_pkg.sv
// Shared types and defaults for the down-counter scheduler.
// The top's optional pause input is controlled by the DOWN_CNT_PAUSE_EN macro.
package down_counter_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request strictly after ptr, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant_nxt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // i runs 1..N_REQ so the current pointer holder has the lowest priority.
  always_comb begin
    grant_nxt = '0;
    idx       = '0;
    valid     = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!valid && req[(int'(ptr) + i) % N_REQ]) begin
        valid = 1'b1;
        idx   = IDX_W'((int'(ptr) + i) % N_REQ);
      end
    end
    if (valid) grant_nxt[idx] = 1'b1;
  end

endmodule

// File: rtl/down_counter_sched.sv
// Round-robin scheduler sharing one down-counter between N_REQ requesters.
// Optional feature: define DOWN_CNT_PAUSE_EN to add a pause input that freezes counting.
module down_counter_sched
  import down_counter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] load_val,
`ifdef DOWN_CNT_PAUSE_EN
  input  logic                   pause,
`endif
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic [WIDTH-1:0]       cnt,
  output logic [N_REQ-1:0]       done
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   cnt_nxt;
  logic [N_REQ-1:0]   grant_nxt, done_nxt, arb_grant;
  logic [IDX_W-1:0]   ptr, ptr_nxt, arb_idx;
  logic               arb_valid, owner_req, hold;
  logic [WIDTH-1:0]   owner_val;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant_nxt (arb_grant),
    .idx       (arb_idx),
    .valid     (arb_valid)
  );

  // The pointer is updated at grant time, so it always names the current owner.
  assign owner_req = req[ptr];
  assign owner_val = load_val[int'(ptr)*WIDTH +: WIDTH];
  assign busy      = (state != ST_IDLE);

`ifdef DOWN_CNT_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      grant <= '0;
      done  <= '0;
      ptr   <= IDX_W'(N_REQ - 1);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      grant <= grant_nxt;
      done  <= done_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant_nxt = grant;
    done_nxt  = '0;
    ptr_nxt   = ptr;
    case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_nxt = arb_grant;
          ptr_nxt   = arb_idx;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!owner_req) begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = owner_val;
          if (owner_val == '0) begin
            state_nxt = ST_DONE;
            done_nxt  = grant;
          end else begin
            state_nxt = ST_COUNT;
          end
        end
      end
      // Withdrawal outranks pause; the final step lands on zero and never wraps.
      ST_COUNT: begin
        if (!owner_req) begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
          cnt_nxt   = '0;
        end else if (!hold) begin
          if (cnt <= WIDTH'(1)) begin
            cnt_nxt   = '0;
            state_nxt = ST_DONE;
            done_nxt  = grant;
          end else begin
            cnt_nxt = cnt - WIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        grant_nxt = '0;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_down_counter_sched.sv
// Self-checking bench for down_counter_sched: directed scenarios plus randomized traffic against a transaction-level model.
// Exercises the pause input when DOWN_CNT_PAUSE_EN is defined.
module tb_down_counter_sched;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] load_val = '0;
  logic           pause = 1'b0;
  logic [N-1:0]   grant, done;
  logic           busy;
  logic [W-1:0]   cnt;

  int total = 0;
  int bad = 0;
  bit seen_reset = 1'b0;

  // Model: owner index (-1 = none), remaining count, and whether the owner is in its load or final cycle.
  int m_own = -1;
  int m_ptr = N - 1;
  int m_rem = 0;
  bit m_loading = 1'b0;
  bit m_fin = 1'b0;

  always #5 clk = ~clk;

  down_counter_sched #(.N_REQ(N), .WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .load_val (load_val),
`ifdef DOWN_CNT_PAUSE_EN
    .pause    (pause),
`endif
    .grant    (grant),
    .busy     (busy),
    .cnt      (cnt),
    .done     (done)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 1; i <= N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit pz;
    int s;
    pz = 1'b0;
`ifdef DOWN_CNT_PAUSE_EN
    pz = pause;
`endif
    if (!rst) begin
      m_own = -1; m_ptr = N - 1; m_rem = 0; m_loading = 0; m_fin = 0;
      seen_reset = 1'b1;
    end else if (m_own < 0) begin
      s = pick(req, m_ptr);
      if (s >= 0) begin
        m_own = s; m_ptr = s; m_loading = 1; m_rem = 0;
      end
    end else if (m_fin) begin
      m_own = -1; m_fin = 0; m_rem = 0;
    end else if (!req[m_own]) begin
      m_own = -1; m_loading = 0; m_rem = 0;
    end else if (m_loading) begin
      m_loading = 0;
      m_rem = int'(load_val[m_own*W +: W]);
      m_fin = (m_rem == 0);
    end else if (!pz) begin
      m_rem = m_rem - 1;
      m_fin = (m_rem == 0);
    end
  endtask

  // Model advances on each edge from the inputs held there, then outputs are compared just after.
  always begin
    @(posedge clk);
    model_step();
    #1;
    if (seen_reset) begin
      check_output("grant", 32'(grant), (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
      check_output("cnt",   32'(cnt),   32'(m_rem));
      check_output("done",  32'(done),  (m_fin && m_own >= 0) ? (32'd1 << m_own) : 32'd0);
      check_output("busy",  32'(busy),  32'(m_own >= 0));
    end
  end

  task automatic apply_stimulus(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k;
    @(negedge clk);
    rst = 1'b0; req = 4'b1111; load_val = 16'h1111;
    apply_stimulus(2);
    check_output("rst_grant", 32'(grant), 0);
    check_output("rst_cnt",   32'(cnt),   0);
    check_output("rst_done",  32'(done),  0);
    check_output("rst_busy",  32'(busy),  0);
    rst = 1'b1;
    apply_stimulus(1);
    check_output("rot0", 32'(grant), 32'b0001);
    apply_stimulus(2);
    check_output("rot0_done", 32'(done), 32'b0001);
    apply_stimulus(2);
    check_output("rot1", 32'(grant), 32'b0010);
    apply_stimulus(4);
    check_output("rot2", 32'(grant), 32'b0100);
    apply_stimulus(4);
    check_output("rot3", 32'(grant), 32'b1000);
    apply_stimulus(4);
    check_output("rot4", 32'(grant), 32'b0001);
    req = '0;
    apply_stimulus(4);

    req = 4'b0100; load_val = 16'h0300;
    apply_stimulus(1);
    check_output("t2_grant", 32'(grant), 32'b0100);
    apply_stimulus(1); check_output("t2_cnt3", 32'(cnt), 3);
    apply_stimulus(1); check_output("t2_cnt2", 32'(cnt), 2);
    apply_stimulus(1); check_output("t2_cnt1", 32'(cnt), 1);
    check_output("t2_nodone", 32'(done), 0);
    apply_stimulus(1);
    check_output("t2_cnt0", 32'(cnt), 0);
    check_output("t2_done", 32'(done), 32'b0100);
    req = '0;
    apply_stimulus(1);
    check_output("t2_idle", 32'(busy), 0);

    load_val = '0; req = 4'b0001;
    apply_stimulus(1);
    check_output("t4_grant", 32'(grant), 32'b0001);
    apply_stimulus(1);
    check_output("t4_done", 32'(done), 32'b0001);
    req = '0;
    apply_stimulus(1);
    check_output("t4_idle", 32'(busy), 0);

    load_val = 16'h00F0; req = 4'b0110;
    apply_stimulus(1);
    check_output("t5_grant", 32'(grant), 32'b0010);
    apply_stimulus(1);
    check_output("t5_cnt15", 32'(cnt), 15);
    apply_stimulus(6);
    check_output("t5_cnt9", 32'(cnt), 9);
    req = 4'b0100;
    apply_stimulus(1);
    check_output("t5_abort_grant", 32'(grant), 0);
    check_output("t5_abort_cnt",   32'(cnt),   0);
    check_output("t5_abort_done",  32'(done),  0);
    apply_stimulus(1);
    check_output("t5_next", 32'(grant), 32'b0100);
    req = '0;
    apply_stimulus(3);

`ifdef DOWN_CNT_PAUSE_EN
    load_val = 16'h0005; req = 4'b0001;
    apply_stimulus(1);
    check_output("t6_grant", 32'(grant), 32'b0001);
    apply_stimulus(3);
    check_output("t6_cnt3", 32'(cnt), 3);
    pause = 1'b1;
    apply_stimulus(3);
    check_output("t6_hold", 32'(cnt), 3);
    pause = 1'b0;
    apply_stimulus(2);
    check_output("t6_cnt1", 32'(cnt), 1);
    check_output("t6_nodone", 32'(done), 0);
    apply_stimulus(1);
    check_output("t6_done", 32'(done), 32'b0001);
    req = '0;
    apply_stimulus(2);
`endif

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(7, 0) == 0) begin
        k = int'($urandom_range(N - 1, 0));
        req[k] = ~req[k];
      end
      if ($urandom_range(3, 0) == 0) load_val = (N*W)'($urandom);
      pause = ($urandom_range(3, 0) == 0);
      rst = ($urandom_range(149, 0) != 0);
    end
    @(negedge clk);
    rst = 1'b1; req = '0; pause = 1'b0;
    apply_stimulus(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
